level_calibrator: RTL and testbench

- Downstream consumer of the button debouncer's single-cycle pulses (clear, save-high, save-low).
- Holds the empty and full calibration points captured from the raw sensor reading.
- Converts each new raw sample into a 0–100 % fill level using a multi-cycle sequential divider.
- Feeds the display/level-output logic.

---
 rtl/level_calibrator_pkg.sv | 20 ++
 rtl/level_calibrator_if.sv | 31 +++
 rtl/level_calibrator_seq_divider.sv | 51 +++++
 rtl/level_calibrator.sv | 136 +++++++++++++
 tb/tb_level_calibrator.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/level_calibrator_pkg.sv
// Shared constants and types for the liquid-level meter calibration path.
package level_calibrator_pkg;

  localparam int LC_RAW_W     = 12;
  localparam int LC_PCT_MAX   = 100;
  localparam int LC_DIV_STEPS = 19;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    CLAMP_NONE,
    CLAMP_ZERO,
    CLAMP_FULL,
    CLAMP_ERR
  } clamp_t;

endpackage

// File: rtl/level_calibrator_if.sv
// Sample, calibration-pulse and level-result bundle between sensor front end and calibrator.
interface level_calibrator_if
  import level_calibrator_pkg::*;
#(
  parameter int RAW_W = LC_RAW_W
) ();

  logic [RAW_W-1:0] raw_value;
  logic             raw_valid;
  logic             cal_clear;
  logic             save_high;
  logic             save_low;
  logic [6:0]       level_pct;
  logic             level_valid;
  logic             level_err;
  logic [RAW_W-1:0] cal_high;
  logic [RAW_W-1:0] cal_low;
  logic             cal_ok;
  logic             busy;

  modport master (
    output raw_value, raw_valid, cal_clear, save_high, save_low,
    input  level_pct, level_valid, level_err, cal_high, cal_low, cal_ok, busy
  );

  modport slave (
    input  raw_value, raw_valid, cal_clear, save_high, save_low,
    output level_pct, level_valid, level_err, cal_high, cal_low, cal_ok, busy
  );

endinterface

// File: rtl/level_calibrator_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock. 'done' is high during the
// cycle whose edge performs the final step; quot is valid from the following cycle.
module level_calibrator_seq_divider
  import level_calibrator_pkg::*;
#(
  parameter int NUM_W = LC_DIV_STEPS,
  parameter int DEN_W = LC_RAW_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic [NUM_W-1:0] quot,
  output logic             done
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [CNT_W-1:0] cnt;
  logic [DEN_W-1:0] rem;
  logic [NUM_W-1:0] q;
  logic [DEN_W:0]   shifted;
  logic             fits;

  // Partial remainder is one bit wider than the divisor before the trial subtract.
  always_comb begin
    shifted = {rem, q[NUM_W-1]};
    fits    = shifted >= {1'b0, den};
  end

  assign done = (cnt == CNT_W'(1));
  assign quot = q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      rem <= '0;
      q   <= '0;
    end else if (start) begin
      cnt <= CNT_W'(NUM_W);
      rem <= '0;
      q   <= num;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      rem <= DEN_W'(fits ? (shifted - {1'b0, den}) : shifted);
      q   <= {q[NUM_W-2:0], fits};
    end
  end

endmodule

// File: rtl/level_calibrator.sv
// Holds empty/full calibration points and converts each raw sample to a 0..PCT_MAX level.
//   state   | meaning
//   IDLE    | waiting for raw_valid; snapshots sample and calibration
//   PREP    | builds numerator/denominator, latches clamp code, starts divider
//   DIV     | divider running, fixed 19 steps regardless of clamp
//   DONE    | publishes level_pct/level_err with a one-cycle level_valid
module level_calibrator
  import level_calibrator_pkg::*;
#(
  parameter int RAW_W   = LC_RAW_W,
  parameter int PCT_MAX = LC_PCT_MAX
) (
  input  logic         clk_100MHz,
  input  logic         reset,
  level_calibrator_if.slave bus
);

  localparam int NUM_W = RAW_W + 7;

  logic [1:0]       state;
  logic [RAW_W-1:0] raw_last;
  logic [RAW_W-1:0] cal_high;
  logic [RAW_W-1:0] cal_low;
  logic [RAW_W-1:0] sample;
  logic [RAW_W-1:0] snap_high;
  logic [RAW_W-1:0] snap_low;
  clamp_t           clamp;
  clamp_t           clamp_next;
  logic [6:0]       level_pct;
  logic             level_valid;
  logic             level_err;
  logic             busy;
  logic [NUM_W-1:0] span_x;
  logic [NUM_W-1:0] div_num;
  logic [RAW_W-1:0] div_den;
  logic [NUM_W-1:0] div_quot;
  logic             div_done;

  assign bus.level_pct   = level_pct;
  assign bus.level_valid = level_valid;
  assign bus.level_err   = level_err;
  assign bus.cal_high    = cal_high;
  assign bus.cal_low     = cal_low;
  assign bus.cal_ok      = cal_high > cal_low;
  assign bus.busy        = busy;

  // x*100 as shifts; only meaningful when the clamp code is NONE.
  always_comb begin
    span_x  = NUM_W'(sample - snap_low);
    div_num = (span_x << 6) + (span_x << 5) + (span_x << 2);
    div_den = snap_high - snap_low;
    clamp_next = CLAMP_NONE;
    if (snap_high <= snap_low)       clamp_next = CLAMP_ERR;
    else if (sample <= snap_low)     clamp_next = CLAMP_ZERO;
    else if (sample >= snap_high)    clamp_next = CLAMP_FULL;
  end

  level_calibrator_seq_divider #(
    .NUM_W (NUM_W),
    .DEN_W (RAW_W)
  ) u_div (
    .clk   (clk_100MHz),
    .rst   (reset),
    .start (state == ST_PREP),
    .num   (div_num),
    .den   (div_den),
    .quot  (div_quot),
    .done  (div_done)
  );

  // Saves read raw_last before this cycle's raw_valid updates it.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      raw_last <= '0;
      cal_high <= '1;
      cal_low  <= '0;
    end else begin
      if (bus.raw_valid) raw_last <= bus.raw_value;
      if (bus.cal_clear) begin
        cal_high <= '1;
        cal_low  <= '0;
      end else begin
        if (bus.save_high) cal_high <= raw_last;
        if (bus.save_low)  cal_low  <= raw_last;
      end
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      sample      <= '0;
      snap_high   <= '0;
      snap_low    <= '0;
      clamp       <= CLAMP_NONE;
      level_pct   <= '0;
      level_valid <= 1'b0;
      level_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.raw_valid) begin
            sample    <= bus.raw_value;
            snap_high <= cal_high;
            snap_low  <= cal_low;
            busy      <= 1'b1;
            state     <= ST_PREP;
          end
        end
        ST_PREP: begin
          clamp <= clamp_next;
          state <= ST_DIV;
        end
        ST_DIV: begin
          if (div_done) state <= ST_DONE;
        end
        ST_DONE: begin
          level_valid <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_IDLE;
          level_err   <= (clamp == CLAMP_ERR);
          case (clamp)
            CLAMP_ERR:  level_pct <= '0;
            CLAMP_ZERO: level_pct <= '0;
            CLAMP_FULL: level_pct <= 7'(PCT_MAX);
            default:    level_pct <= 7'(div_quot);
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_level_calibrator.sv
// Scoreboard bench for level_calibrator: expected levels queued at stimulus, checked on level_valid.
module tb_level_calibrator;
  import level_calibrator_pkg::*;

  logic clk_100MHz = 1'b0;
  logic reset      = 1'b1;

  level_calibrator_if #(.RAW_W(12)) bus ();

  level_calibrator #(.RAW_W(12), .PCT_MAX(100)) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    int pct;
    int err;
    int edge_k;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   m_lo, m_hi, m_last, next_free;

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lo      = 0;
    m_hi      = 4095;
    m_last    = 0;
    next_free = 0;
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input bit v, input int raw, input bit clr, input bit sh, input bit sl);
    int   k;
    exp_t e;
    bus.raw_valid = v;
    bus.raw_value = 12'(raw);
    bus.cal_clear = clr;
    bus.save_high = sh;
    bus.save_low  = sl;
    k = cyc + 1;
    if (v && k >= next_free) begin
      e.err = 0;
      if (m_hi <= m_lo) begin
        e.pct = 0;
        e.err = 1;
      end else if (raw <= m_lo) e.pct = 0;
      else if (raw >= m_hi)     e.pct = 100;
      else                      e.pct = ((raw - m_lo) * 100) / (m_hi - m_lo);
      e.edge_k = k;
      sb.push_back(e);
      next_free = k + 22;
    end
    if (clr) begin
      m_lo = 0;
      m_hi = 4095;
    end else begin
      if (sh) m_hi = m_last;
      if (sl) m_lo = m_last;
    end
    if (v) m_last = raw;
    @(posedge clk_100MHz);
    #1;
    bus.raw_valid = 1'b0;
    bus.raw_value = '0;
    bus.cal_clear = 1'b0;
    bus.save_high = 1'b0;
    bus.save_low  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() != 0 && b < 60) begin
      step(0, 0, 0, 0, 0);
      b++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    step(0, 0, 0, 0, 0);
  endtask

  always @(negedge clk_100MHz) begin
    if (bus.level_valid === 1'b1) begin
      if (sb.size() == 0) chk("spurious_valid", bus.level_valid, 0);
      else begin
        mon_e = sb.pop_front();
        chk("level_pct", bus.level_pct, mon_e.pct);
        chk("level_err", bus.level_err, mon_e.err);
        chk("latency", cyc - mon_e.edge_k, 21);
      end
    end
  end

  initial begin
    bus.raw_valid = 1'b0;
    bus.raw_value = '0;
    bus.cal_clear = 1'b0;
    bus.save_high = 1'b0;
    bus.save_low  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_100MHz);
    #1;
    chk("rst_cal_low", bus.cal_low, 0);
    chk("rst_cal_high", bus.cal_high, 4095);
    chk("rst_level_pct", bus.level_pct, 0);
    chk("rst_level_valid", bus.level_valid, 0);
    chk("rst_level_err", bus.level_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cal_ok", bus.cal_ok, 1);
    reset = 1'b0;
    idle(2);

    // default calibration 0..4095
    step(1, 4095, 0, 0, 0);
    chk("busy_set", bus.busy, 1);
    drain();
    chk("pct_full_default", bus.level_pct, 100);
    step(1, 2048, 0, 0, 0);
    drain();
    chk("pct_half_default", bus.level_pct, 50);
    chk("busy_clear", bus.busy, 0);
    chk("cal_ok_default", bus.cal_ok, 1);

    // calibrate to 1000..3000; 3000 arrives while busy but still reaches raw_last
    step(1, 1000, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 3000, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    drain();
    chk("cal_low_1000", bus.cal_low, 1000);
    chk("cal_high_3000", bus.cal_high, 3000);
    foreach (sb[i]) chk("sb_not_empty", sb.size(), 0);
    step(1, 2000, 0, 0, 0); drain();
    chk("pct_2000", bus.level_pct, 50);
    step(1, 2999, 0, 0, 0); drain();
    chk("pct_2999", bus.level_pct, 99);
    step(1, 500, 0, 0, 0);  drain();
    step(1, 3500, 0, 0, 0); drain();

    // throughput edge: k+21 is dropped, k+22 is accepted
    step(1, 2000, 0, 0, 0);
    idle(20);
    step(1, 2500, 0, 0, 0);
    step(1, 3000, 0, 0, 0);
    drain();

    // equal save -> invalid calibration
    step(1, 1500, 0, 0, 0); drain();
    step(0, 0, 0, 1, 1);
    chk("eq_cal_high", bus.cal_high, 1500);
    chk("eq_cal_low", bus.cal_low, 1500);
    chk("eq_cal_ok", bus.cal_ok, 0);
    step(1, 1800, 0, 0, 0); drain();
    chk("err_hold", bus.level_err, 1);

    // back to 1000..3000
    step(1, 1000, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    drain();
    step(1, 3000, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    drain();
    chk("err_cleared", bus.level_err, 0);

    // second sample and save_high mid-conversion
    step(1, 2000, 0, 0, 0);
    idle(4);
    step(1, 2600, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    drain();
    chk("cal_high_2600", bus.cal_high, 2600);
    step(1, 2000, 0, 0, 0); drain();
    chk("pct_after_change", bus.level_pct, 62);

    // reset during divide
    step(1, 3000, 0, 0, 0);
    idle(11);
    reset = 1'b1;
    sb.delete();
    #2;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_valid", bus.level_valid, 0);
    chk("midrst_cal_high", bus.cal_high, 4095);
    chk("midrst_cal_low", bus.cal_low, 0);
    @(posedge clk_100MHz);
    #1;
    reset = 1'b0;
    model_reset();
    idle(30);
    step(1, 3000, 0, 0, 0); drain();
    chk("pct_after_rst", bus.level_pct, 73);

    // clear beats save
    step(1, 2000, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    drain();
    chk("clr_cal_high", bus.cal_high, 4095);
    chk("clr_cal_low", bus.cal_low, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
